// File: rtl/jlsemi_util_reset_seq_ctrl.sv
// Reset release sequencer: holds all domains in reset, then releases them one at a
// time (domain 0 first) with a programmable gap, plus a soft-reset handshake.
module jlsemi_util_reset_seq_ctrl #(
  parameter int unsigned NUM_DOM  = 4,
  parameter int unsigned HOLD_CYC = 8,
  parameter int unsigned GAP_W    = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [GAP_W-1:0]   gap_cfg_i,
  input  logic               soft_rst_req_i,
  output logic               soft_rst_ack_o,
  output logic [NUM_DOM-1:0] dom_rst_n_o,
  output logic               seq_done_o,
  input  logic               dft_rstnsync_scan_rstn_ctrl,
  input  logic               dft_rstnsync_scan_rstn
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int unsigned CNT_W  = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
  localparam int unsigned IDX_W  = $clog2(NUM_DOM);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd1,
    S_REL  = 3'd2,
    S_DONE = 3'd3,
    S_SOFT = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [GAP_W-1:0]   r_gap_q;
  logic               r_pend;
  logic               r_soft_path;
  logic [NUM_DOM-1:0] r_dom;
  logic               r_done;
  logic               r_ack;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic               w_pend_nxt;
  logic               w_soft_nxt;
  logic [NUM_DOM-1:0] w_dom_nxt;
  logic               w_done_nxt;
  logic               w_ack_nxt;
  logic               w_gap_hit;

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_gap_q     <= '0;
      r_pend      <= 1'b0;
      r_soft_path <= 1'b0;
      r_dom       <= '0;
      r_done      <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_gap_q     <= w_gap_nxt;
      r_pend      <= w_pend_nxt;
      r_soft_path <= w_soft_nxt;
      r_dom       <= w_dom_nxt;
      r_done      <= w_done_nxt;
      r_ack       <= w_ack_nxt;
    end
  end

  // Saturating counter step; the counter never needs to exceed gap_q or HOLD_CYC-1
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_gap_hit = (r_cnt == CNT_W'(r_gap_q));

  // Next-state logic; en_i low overrides everything, including a soft request
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap_q;
    w_pend_nxt  = r_pend;
    w_soft_nxt  = r_soft_path;

    if (!en_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_pend_nxt  = 1'b0;
      w_soft_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_gap_nxt   = gap_cfg_i;
        end
        S_HOLD: begin
          w_pend_nxt = r_pend | (soft_rst_req_i & ~r_soft_path);
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = S_REL;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_REL: begin
          w_pend_nxt = r_pend | (soft_rst_req_i & ~r_soft_path);
          if (w_gap_hit) begin
            w_cnt_nxt = '0;
            if (r_idx == IDX_LAST) begin
              w_state_nxt = S_DONE;
              w_soft_nxt  = 1'b0;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_DONE: begin
          // A new request is only taken once the previous ack has dropped
          if ((soft_rst_req_i || r_pend) && !r_ack) begin
            w_state_nxt = S_SOFT;
            w_gap_nxt   = gap_cfg_i;
            w_pend_nxt  = 1'b0;
            w_soft_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
          end
        end
        S_SOFT: begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_pend_nxt  = 1'b0;
          w_soft_nxt  = 1'b0;
        end
      endcase
    end
  end

  // Output values for the next cycle, derived from the next state (thermometer release)
  always_comb begin
    w_dom_nxt  = '0;
    w_done_nxt = (w_state_nxt == S_DONE);
    w_ack_nxt  = 1'b0;
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      w_dom_nxt[i] = (w_state_nxt == S_DONE) ||
                     ((w_state_nxt == S_REL) && (IDX_W'(i) <= w_idx_nxt));
    end
    if (w_state_nxt == S_DONE) begin
      w_ack_nxt = (r_state == S_DONE) ? (r_ack & soft_rst_req_i) : r_soft_path;
    end
  end

  // Scan override sits after the register so test mode never depends on the FSM
  assign dom_rst_n_o    = dft_rstnsync_scan_rstn_ctrl ? {NUM_DOM{dft_rstnsync_scan_rstn}} : r_dom;
  assign seq_done_o     = r_done;
  assign soft_rst_ack_o = r_ack;

endmodule

// File: tb/tb_jlsemi_util_reset_seq_ctrl.sv
// Bench for jlsemi_util_reset_seq_ctrl: directed spec scenarios plus random stimulus,
// checked against an elapsed-time reference model.
module tb_jlsemi_util_reset_seq_ctrl;

  localparam int unsigned NUM  = 4;
  localparam int unsigned HOLD = 4;
  localparam int unsigned GW   = 8;

  logic          clk;
  logic          rst;
  logic          en;
  logic [GW-1:0] gap;
  logic          req;
  logic          ack;
  logic [NUM-1:0] dom;
  logic          done;
  logic          dctl;
  logic          dval;

  int total;
  int bad;

  // Reference model: sequence position expressed as cycles elapsed since HOLD entry
  int m_run;
  int m_softcyc;
  int m_e;
  int m_g;
  int m_soft;
  int m_ack;
  int m_pend;

  jlsemi_util_reset_seq_ctrl #(
    .NUM_DOM (NUM),
    .HOLD_CYC(HOLD),
    .GAP_W   (GW)
  ) u_dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .en_i                       (en),
    .gap_cfg_i                  (gap),
    .soft_rst_req_i             (req),
    .soft_rst_ack_o             (ack),
    .dom_rst_n_o                (dom),
    .seq_done_o                 (done),
    .dft_rstnsync_scan_rstn_ctrl(dctl),
    .dft_rstnsync_scan_rstn     (dval)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int t_done();
    return int'(HOLD) + int'(NUM) * (m_g + 1);
  endfunction

  function automatic logic [NUM-1:0] exp_dom();
    int n;
    if (m_run == 0 || m_softcyc != 0) return '0;
    if (m_e < int'(HOLD)) n = 0;
    else n = (m_e - int'(HOLD)) / (m_g + 1) + 1;
    if (n > int'(NUM)) n = int'(NUM);
    return NUM'((1 << n) - 1);
  endfunction

  function automatic logic exp_done();
    return (m_run != 0) && (m_softcyc == 0) && (m_e >= t_done());
  endfunction

  task automatic model_reset();
    m_run = 0; m_softcyc = 0; m_e = 0; m_g = 0;
    m_soft = 0; m_ack = 0; m_pend = 0;
  endtask

  task automatic model_edge();
    if (!en) begin
      m_run = 0; m_softcyc = 0; m_ack = 0; m_pend = 0; m_soft = 0;
    end else if (m_run == 0) begin
      m_run = 1; m_e = 0; m_g = int'(gap);
    end else if (m_softcyc != 0) begin
      m_softcyc = 0; m_e = 0;
    end else if (m_e < t_done()) begin
      if (req && m_soft == 0) m_pend = 1;
      m_e++;
      if (m_e == t_done()) begin
        m_ack = m_soft; m_soft = 0;
      end
    end else begin
      if ((req || m_pend != 0) && m_ack == 0) begin
        m_softcyc = 1; m_g = int'(gap); m_pend = 0; m_soft = 1;
      end else begin
        m_ack = (m_ack != 0 && req) ? 1 : 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    logic [NUM-1:0] ed;
    ed = dctl ? {NUM{dval}} : exp_dom();
    chk("dom", 32'(dom), 32'(ed));
    chk("done", 32'(done), 32'(exp_done()));
    chk("ack", 32'(ack), 32'(m_ack));
    if (!dctl) chk("thermo", 32'((dom & (dom + NUM'(1))) == '0), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_out();
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    logic [NUM-1:0] v;
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; req = 1'b0; dctl = 1'b0; dval = 1'b0; gap = '0;
    model_reset();
    #12;
    check_out();
    @(posedge clk);
    #1;
    rst = 1'b0;
    steps(2);

    // gap 2 release timeline from the spec table
    gap = 8'd2; en = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      step();
      v = (i >= 14) ? 4'hF : (i >= 11) ? 4'h7 : (i >= 8) ? 4'h3 : (i >= 5) ? 4'h1 : 4'h0;
      chk("tp1_dom", 32'(dom), 32'(v));
      chk("tp1_done", 32'(done), 32'(i >= 17));
    end

    // gap 0: back-to-back releases, mid-sequence gap change ignored
    en = 1'b0; step();
    gap = 8'd0; en = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      v = (i >= 8) ? 4'hF : (i == 7) ? 4'h7 : (i == 6) ? 4'h3 : (i == 5) ? 4'h1 : 4'h0;
      chk("tp2_dom", 32'(dom), 32'(v));
      chk("tp2_done", 32'(done), 32'(i >= 9));
      if (i == 6) gap = 8'd5;
    end

    // en drop mid-REL, re-enable
    en = 1'b0; step();
    gap = 8'd2; en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 9)  chk("tp3_pre_drop", 32'(dom), 32'h3);
      if (i == 10) chk("tp3_dropped", 32'(dom), 32'h0);
      if (i == 16) chk("tp3_rehold", 32'(dom), 32'h0);
      if (i == 17) chk("tp3_rel0", 32'(dom), 32'h1);
      if (i == 9) en = 1'b0;
      if (i == 12) en = 1'b1;
    end
    steps(15);

    // Soft reset handshake from DONE
    chk("soft_pre_done", 32'(done), 32'd1);
    req = 1'b1;
    step();
    chk("soft_clr", 32'(dom), 32'h0);
    steps(17);
    chk("soft_ack_set", 32'(ack), 32'd1);
    chk("soft_done_set", 32'(done), 32'd1);
    steps(3);
    req = 1'b0;
    step();
    chk("soft_ack_drop", 32'(ack), 32'd0);

    // Request pulsed during HOLD is held pending and serviced at DONE
    en = 1'b0; step();
    en = 1'b1; steps(2);
    req = 1'b1; step();
    req = 1'b0; steps(40);

    // DFT override in several states
    en = 1'b0; step();
    en = 1'b1; gap = 8'd1;
    dctl = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      dval = ~dval;
      #1;
      chk("dft_same_cycle", 32'(dom), 32'({NUM{dval}}));
    end
    dctl = 1'b0;
    #1;
    check_out();
    steps(5);

    // Asynchronous reset mid-REL
    en = 1'b0; step();
    en = 1'b1; gap = 8'd2; steps(7);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dom", 32'(dom), 32'h0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    model_reset();
    steps(2);
    rst = 1'b0;
    steps(20);

    // Maximum gap: 2^GAP_W cycles between releases
    en = 1'b0; step();
    gap = 8'hFF; en = 1'b1;
    steps(10);
    gap = 8'd3;
    steps(int'(HOLD) + int'(NUM) * 256 - 6);

    // Random stimulus
    for (int i = 0; i < 1500; i++) begin
      step();
      gap = GW'($urandom_range(0, 3));
      if (en) begin
        if ($urandom_range(0, 79) == 0) en = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) en = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) req = ~req;
      if ($urandom_range(0, 49) == 0) dctl = ~dctl;
      dval = 1'($urandom);
    end
    dctl = 1'b0;
    steps(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
